// File: rtl/ariane_pkg.sv
// Slice of ariane_pkg: the D$ request-port types and the responder latency bound.
package ariane_pkg;

    localparam int DCACHE_INDEX_WIDTH = 12;
    localparam int DCACHE_TAG_WIDTH   = 44;

    // Upper bound for the responder's programmable read latency
    localparam int DCACHE_RESP_MAX_LAT = 4;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [63:0]                   data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [7:0]                    data_be;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [63:0] data_rdata;
    } dcache_req_o_t;

endpackage

// File: rtl/dcache_resp_sram.sv
// Backing store for the D$ port responder: byte-enabled synchronous write,
// asynchronous read so the tag cycle sees the word before that edge's write.
module dcache_resp_sram #(
    parameter int MEM_WORDS = 1024
) (
    input  logic                         clk_i,
    input  logic                         we_i,
    input  logic [$clog2(MEM_WORDS)-1:0] waddr_i,
    input  logic [63:0]                  wdata_i,
    input  logic [7:0]                   be_i,
    input  logic [$clog2(MEM_WORDS)-1:0] raddr_i,
    output logic [63:0]                  rdata_o
);

    logic [63:0] mem_q [MEM_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 8; b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dcache_port_responder.sv
// Memory-backed responder for one D$ request port: index phase, grant, tag
// phase, kill, and an in-order read pipe with programmable latency.
module dcache_port_responder
    import ariane_pkg::*;
#(
    parameter int MEM_WORDS  = 1024,
    parameter int RD_LATENCY = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  dcache_req_i_t req_port_i,
    output dcache_req_o_t req_port_o,
    input  logic          stall_i,
    output logic          busy_o
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_TAG = 1'b1;

    if (RD_LATENCY < 1 || RD_LATENCY > DCACHE_RESP_MAX_LAT) begin : g_bad_latency
        $error("dcache_port_responder: RD_LATENCY must be in 1..DCACHE_RESP_MAX_LAT");
    end
    if (MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_words
        $error("dcache_port_responder: MEM_WORDS must be a power of 2");
    end

    logic [0:0]  state_q, state_d;
    logic [11:0] idx_q, idx_d;
    logic        gnt;
    logic        load_gnt;
    logic        tag_hit;
    logic [55:0] st_addr;
    logic [55:0] ld_addr;
    logic [63:0] rd_word;

    assign st_addr = {req_port_i.address_tag, req_port_i.address_index};
    assign ld_addr = {req_port_i.address_tag, idx_q};

    assign gnt = req_port_i.data_req & ~stall_i &
                 ((state_q == IDLE) |
                  ((state_q == WAIT_TAG) & req_port_i.tag_valid & ~req_port_i.kill_req));
    assign load_gnt = gnt & ~req_port_i.data_we;
    assign tag_hit  = (state_q == WAIT_TAG) & req_port_i.tag_valid & ~req_port_i.kill_req;

    // A load grant in the tag cycle overrides the return to IDLE
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == WAIT_TAG && (req_port_i.kill_req || req_port_i.tag_valid)) begin
            state_d = IDLE;
        end
        if (load_gnt) begin
            state_d = WAIT_TAG;
            idx_d   = req_port_i.address_index;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    dcache_resp_sram #(
        .MEM_WORDS(MEM_WORDS)
    ) u_sram (
        .clk_i  (clk_i),
        .we_i   (gnt & req_port_i.data_we),
        .waddr_i(st_addr[3 +: AW]),
        .wdata_i(req_port_i.data_wdata),
        .be_i   (req_port_i.data_be),
        .raddr_i(ld_addr[3 +: AW]),
        .rdata_o(rd_word)
    );

    logic unused_bits;
    assign unused_bits = ^{st_addr[2:0], st_addr[55:3+AW], ld_addr[2:0], ld_addr[55:3+AW],
                           req_port_i.data_size};

    // Read pipe: entry 0 of the chain is the tag-cycle sample, entry RD_LATENCY the output
    logic [RD_LATENCY:0] chain_vld;
    logic [63:0]         chain_data [RD_LATENCY+1];
    logic [RD_LATENCY-1:0] vld_q;
    logic [63:0]           data_q [RD_LATENCY];
    logic                  rdata_seen_q;

    always_comb begin
        chain_vld[0]  = tag_hit;
        chain_data[0] = rd_word;
        for (int i = 0; i < RD_LATENCY; i++) begin
            chain_vld[i+1]  = vld_q[i];
            chain_data[i+1] = data_q[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q        <= '0;
            rdata_seen_q <= 1'b0;
        end else begin
            vld_q        <= chain_vld[RD_LATENCY-1:0];
            rdata_seen_q <= rdata_seen_q | chain_vld[RD_LATENCY];
        end
    end

    // Stages load only on a valid entry, so the last one holds the previous word
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < RD_LATENCY; i++) begin
            if (chain_vld[i]) begin
                data_q[i] <= chain_data[i];
            end
        end
    end

    always_comb begin
        req_port_o.data_gnt    = gnt;
        req_port_o.data_rvalid = chain_vld[RD_LATENCY];
        req_port_o.data_rdata  = (rdata_seen_q | chain_vld[RD_LATENCY]) ?
                                 chain_data[RD_LATENCY] : 64'h0;
    end

    assign busy_o = (state_q == WAIT_TAG) | (|vld_q);

endmodule

// File: tb/tb_dcache_port_responder.sv
// Bench for dcache_port_responder: three instances (latency 1, 3, 2) driven by
// directed vectors; a scoreboard queue is checked by a monitor on every rvalid.
module tb_dcache_port_responder;
    import ariane_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dcache_req_i_t req [3];
    dcache_req_o_t rsp [3];
    logic          rst_n [3];
    logic          stall [3];
    logic          busy [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
        dcache_port_responder #(
            .MEM_WORDS (1024),
            .RD_LATENCY(LAT)
        ) u_dut (
            .clk_i     (clk),
            .rst_ni    (rst_n[g]),
            .req_port_i(req[g]),
            .req_port_o(rsp[g]),
            .stall_i   (stall[g]),
            .busy_o    (busy[g])
        );
    end

    typedef struct packed {
        int          k;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every rvalid pulse must match the oldest expected response
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rsp[k].data_rvalid === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rvalid: dut=%0d cycle=%0d rdata=%0h expected no response",
                             k, cyc, rsp[k].data_rdata);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("rvalid_dut", k, mon_e.k);
                    chk("rdata", rsp[k].data_rdata, mon_e.data);
                    chk("rvalid_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clr(input int k);
        req[k] = '0;
    endtask

    task automatic put_store(input int k, input logic [55:0] a, input logic [63:0] wd,
                             input logic [7:0] be);
        req[k].data_req      = 1'b1;
        req[k].data_we       = 1'b1;
        req[k].address_index = a[11:0];
        req[k].address_tag   = a[55:12];
        req[k].data_wdata    = wd;
        req[k].data_be       = be;
        req[k].data_size     = 2'd3;
    endtask

    task automatic put_load(input int k, input logic [11:0] idx);
        req[k].data_req      = 1'b1;
        req[k].data_we       = 1'b0;
        req[k].address_index = idx;
        req[k].data_size     = 2'd3;
    endtask

    task automatic put_tag(input int k, input logic [43:0] tag, input logic [63:0] exp,
                           input int lat);
        exp_t e;
        req[k].tag_valid   = 1'b1;
        req[k].address_tag = tag;
        e.k    = k;
        e.data = exp;
        e.cyc  = cyc + lat;
        sbq.push_back(e);
    endtask

    task automatic chk_gnt(input int k, input logic e);
        #1;
        chk("data_gnt", rsp[k].data_gnt, e);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            req[k]   = '0;
            rst_n[k] = 1'b0;
            stall[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_gnt", rsp[k].data_gnt, 0);
            chk("reset_rvalid", rsp[k].data_rvalid, 0);
            chk("reset_rdata", rsp[k].data_rdata, 0);
            chk("reset_busy", busy[k], 0);
            rst_n[k] = 1'b1;
        end

        // Store then load, latency 1
        next(); put_store(0, 56'h80, 64'h1122334455667788, 8'hFF); chk_gnt(0, 1);
        next(); clr(0); put_load(0, 12'h080); chk_gnt(0, 1);
        next(); clr(0); put_tag(0, 44'h0, 64'h1122334455667788, 1); chk_gnt(0, 0);
        chk("busy_wait_tag", busy[0], 1);
        next(); clr(0);
        next(); chk("busy_idle", busy[0], 0);

        // Partial store, then a store granted in the tag cycle (tag sees old data)
        put_store(0, 56'h80, 64'hAAAAAAAABBBBBBBB, 8'h0F); chk_gnt(0, 1);
        next(); clr(0); put_load(0, 12'h080); chk_gnt(0, 1);
        next(); clr(0); put_tag(0, 44'h0, 64'h11223344BBBBBBBB, 1);
        put_store(0, 56'h80, 64'hCAFEF00D12345678, 8'hFF); chk_gnt(0, 1);
        next(); clr(0); put_load(0, 12'h080); chk_gnt(0, 1);
        next(); clr(0); put_tag(0, 44'h0, 64'hCAFEF00D12345678, 1);
        next(); clr(0);

        // WAIT_TAG hold without tag: no grant for a pending request
        next(); put_load(0, 12'h080); chk_gnt(0, 1);
        next(); clr(0); put_load(0, 12'h100); chk_gnt(0, 0);
        chk("busy_hold", busy[0], 1);
        next(); clr(0); put_tag(0, 44'h0, 64'hCAFEF00D12345678, 1);
        next(); clr(0);

        // Kill (with tag_valid also high): no response, busy drops, new load granted
        next(); put_load(0, 12'h080); chk_gnt(0, 1);
        next(); clr(0); put_load(0, 12'h100);
        req[0].kill_req  = 1'b1;
        req[0].tag_valid = 1'b1;
        chk_gnt(0, 0);
        next(); clr(0); chk("busy_after_kill", busy[0], 0);
        repeat (5) next();
        put_load(0, 12'h080); chk_gnt(0, 1);
        next(); clr(0); put_tag(0, 44'h0, 64'hCAFEF00D12345678, 1);
        next(); clr(0);

        // Backpressure and address wrap (0x2000 aliases word 0)
        next(); put_store(0, 56'h0, 64'h0123456789ABCDEF, 8'hFF); chk_gnt(0, 1);
        next(); clr(0); stall[0] = 1'b1; put_load(0, 12'h000);
        for (int i = 0; i < 3; i++) begin
            chk_gnt(0, 0);
            next();
        end
        stall[0] = 1'b0; chk_gnt(0, 1);
        next(); clr(0); put_tag(0, 44'h2, 64'h0123456789ABCDEF, 1);
        next(); clr(0);

        // Back-to-back loads, latency 3
        next(); put_store(1, 56'h0, 64'hA, 8'hFF); chk_gnt(1, 1);
        next(); clr(1); put_store(1, 56'h8, 64'hB, 8'hFF); chk_gnt(1, 1);
        next(); clr(1); put_load(1, 12'h000); chk_gnt(1, 1);
        next(); clr(1); put_tag(1, 44'h0, 64'hA, 3); put_load(1, 12'h008); chk_gnt(1, 1);
        next(); clr(1); put_tag(1, 44'h0, 64'hB, 3);
        next(); clr(1);
        repeat (4) next();
        chk("rvalid_idle_b2b", rsp[1].data_rvalid, 0);
        chk("rdata_hold_b2b", rsp[1].data_rdata, 64'hB);

        // Reset mid-flight, latency 2
        next(); put_store(2, 56'h40, 64'h5A5A5A5AA5A5A5A5, 8'hFF); chk_gnt(2, 1);
        next(); clr(2); put_load(2, 12'h040); chk_gnt(2, 1);
        next(); clr(2); put_tag(2, 44'h0, 64'h5A5A5A5AA5A5A5A5, 2);
        next(); clr(2);
        next(); next();
        chk("rdata_hold_l2", rsp[2].data_rdata, 64'h5A5A5A5AA5A5A5A5);
        put_load(2, 12'h040); chk_gnt(2, 1);
        next(); clr(2); req[2].tag_valid = 1'b1; req[2].address_tag = 44'h0;
        chk("busy_tag_l2", busy[2], 1);
        next(); clr(2); rst_n[2] = 1'b0;
        #1;
        chk("midrst_rvalid", rsp[2].data_rvalid, 0);
        chk("midrst_rdata", rsp[2].data_rdata, 0);
        chk("midrst_busy", busy[2], 0);
        chk("midrst_gnt", rsp[2].data_gnt, 0);
        next(); next();
        rst_n[2] = 1'b1;
        next(); put_load(2, 12'h040); chk_gnt(2, 1);
        next(); clr(2); put_tag(2, 44'h0, 64'h5A5A5A5AA5A5A5A5, 2);
        next(); clr(2);
        repeat (4) next();

        while (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_rvalid: dut=%0d got no response, expected rdata=%0h at cycle %0d",
                     mon_e.k, mon_e.data, mon_e.cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
